// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, multiply/divide occupancy,
// and taken-branch flushes. Stall and flush controls are combinational so the PC freezes in the detection cycle.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY        = 32,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_is_md,
  input  logic                   id_reads_hilo,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_dest,
  input  logic                   branch_taken_ex,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic                   md_start,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    RUN,
    LD_STALL
  } state_e;

  localparam bit         LD_MULTI    = (LOAD_STALL_CYCLES > 1);
  localparam logic [1:0] LD_RELOAD   = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [5:0] MD_RELOAD   = 6'(MD_LATENCY);

  state_e                 state_q, state_d;
  logic [1:0]             ld_cnt_q, ld_cnt_d;
  logic [5:0]             md_cnt_q, md_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ld_haz;
  logic md_haz;
  logic stall_req;
  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_dest);
    rt_match = id_uses_rt && (id_rt == ex_dest);
    ld_haz   = ex_is_load && (ex_dest != 5'd0) && (rs_match || rt_match);
    md_busy  = (md_cnt_q != 6'd0);
    md_done  = (md_cnt_q == 6'd1);
    md_haz   = (id_is_md || id_reads_hilo) && md_busy;
  end

  // A taken branch overrides every stall: the redirect must be allowed to load the PC.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    md_start     = 1'b0;
    stall_req    = md_haz || (state_q == LD_STALL) || ((state_q == RUN) && ld_haz);
    if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_stall     = stall_req;
      if_id_stall  = stall_req;
      id_ex_bubble = stall_req;
      md_start     = id_is_md && !md_busy && !ld_haz && (state_q == RUN);
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    if (branch_taken_ex) begin
      state_d  = RUN;
      ld_cnt_d = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (ld_haz && LD_MULTI) begin
            state_d  = LD_STALL;
            ld_cnt_d = LD_RELOAD;
          end
        end
        LD_STALL: begin
          ld_cnt_d = ld_cnt_q - 2'd1;
          if (ld_cnt_q <= 2'd1) begin
            state_d  = RUN;
            ld_cnt_d = 2'd0;
          end
        end
        default: begin
          state_d  = RUN;
          ld_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // An in-flight MD operation is older than any branch, so flushes never touch md_cnt.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start) begin
      md_cnt_d = MD_RELOAD;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - 6'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ld_cnt_q    <= 2'd0;
      md_cnt_q    <= 6'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: instance A uses default parameters, instance B uses
// a 3-cycle load stall, 4-cycle MD latency and a 4-bit counter.
module tb_hazard_stall_ctrl;

  logic clk;
  logic rstN;
  logic sel;
  logic [4:0] idRs, idRt, exDest;
  logic idUsesRs, idUsesRt, idIsMd, idReadsHilo, exIsLoad, branchTakenEx;

  logic [20:0] inBus, busA, busB;

  logic pcA, ifidA, bubA, flushA, startA, busyA, doneA;
  logic [15:0] cntA;
  logic pcB, ifidB, bubB, flushB, startB, busyB, doneB;
  logic [3:0] cntB;

  typedef struct {
    string       tag;
    logic [22:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inBus = {idRs, idRt, idUsesRs, idUsesRt, idIsMd, idReadsHilo, exIsLoad, exDest, branchTakenEx};
  assign busA  = sel ? 21'd0 : inBus;
  assign busB  = sel ? inBus : 21'd0;

  hazard_stall_ctrl dutA (
    .clk(clk), .rst_n(rstN),
    .id_rs(busA[20:16]), .id_rt(busA[15:11]), .id_uses_rs(busA[10]), .id_uses_rt(busA[9]),
    .id_is_md(busA[8]), .id_reads_hilo(busA[7]), .ex_is_load(busA[6]), .ex_dest(busA[5:1]),
    .branch_taken_ex(busA[0]),
    .pc_stall(pcA), .if_id_stall(ifidA), .id_ex_bubble(bubA), .if_id_flush(flushA),
    .md_start(startA), .md_busy(busyA), .md_done(doneA), .stall_cnt(cntA)
  );

  hazard_stall_ctrl #(.MD_LATENCY(4), .LOAD_STALL_CYCLES(3), .STALL_CNT_W(4)) dutB (
    .clk(clk), .rst_n(rstN),
    .id_rs(busB[20:16]), .id_rt(busB[15:11]), .id_uses_rs(busB[10]), .id_uses_rt(busB[9]),
    .id_is_md(busB[8]), .id_reads_hilo(busB[7]), .ex_is_load(busB[6]), .ex_dest(busB[5:1]),
    .branch_taken_ex(busB[0]),
    .pc_stall(pcB), .if_id_stall(ifidB), .id_ex_bubble(bubB), .if_id_flush(flushB),
    .md_start(startB), .md_busy(busyB), .md_done(doneB), .stall_cnt(cntB)
  );

  // Expected vector layout: {stall_cnt, done, busy, start, flush, bubble, if_id_stall, pc_stall}.
  function automatic logic [22:0] mkExp(int s, int fl, int st, int bz, int dn, int cnt);
    return {16'(cnt), 1'(dn), 1'(bz), 1'(st), 1'(fl), 1'(s | fl), 1'(s), 1'(s)};
  endfunction

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic md, input logic hilo, input logic ld, input logic [4:0] dest,
                       input logic br);
    @(negedge clk);
    idRs = rs; idRt = rt; idUsesRs = urs; idUsesRt = urt;
    idIsMd = md; idReadsHilo = hilo; exIsLoad = ld; exDest = dest; branchTakenEx = br;
  endtask

  task automatic idleIn();
    setIn(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic checkOutput();
    sbEntry_t ent;
    logic [22:0] got;
    ent = sbQ.pop_front();
    if (sel) got = {12'd0, cntB, doneB, busyB, startB, flushB, bubB, ifidB, pcB};
    else     got = {cntA, doneA, busyA, startA, flushA, bubA, ifidA, pcA};
    total++;
    assert (got === ent.exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", ent.tag, got, ent.exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [22:0] exp);
    sbEntry_t ent;
    ent.tag = tag;
    ent.exp = exp;
    sbQ.push_back(ent);
    #1;
    checkOutput();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 1'b0;
    rstN  = 1'b0;
    idRs = '0; idRt = '0; idUsesRs = 0; idUsesRt = 0; idIsMd = 0; idReadsHilo = 0;
    exIsLoad = 0; exDest = '0; branchTakenEx = 0;
    $display("[TB] start");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    applyStimulus("reset", mkExp(0, 0, 0, 0, 0, 0));

    idleIn(); applyStimulus("idle", mkExp(0, 0, 0, 0, 0, 0));
    setIn(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0); applyStimulus("ldUseRs", mkExp(1, 0, 0, 0, 0, 0));
    idleIn(); applyStimulus("ldRelease", mkExp(0, 0, 0, 0, 0, 1));
    setIn(5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0); applyStimulus("ldZeroReg", mkExp(0, 0, 0, 0, 0, 1));
    setIn(5'd7, 5'd0, 0, 0, 0, 0, 1, 5'd7, 0); applyStimulus("ldRsUnused", mkExp(0, 0, 0, 0, 0, 1));
    setIn(5'd0, 5'd7, 0, 1, 0, 0, 1, 5'd7, 0); applyStimulus("ldUseRt", mkExp(1, 0, 0, 0, 0, 1));
    setIn(5'd0, 5'd7, 0, 1, 0, 0, 0, 5'd7, 0); applyStimulus("notLoad", mkExp(0, 0, 0, 0, 0, 2));

    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); applyStimulus("mdStart", mkExp(0, 0, 1, 0, 0, 2));
    for (int k = 1; k <= 27; k++) begin
      idleIn(); applyStimulus("mdBusy", mkExp(0, 0, 0, 1, 0, 2));
    end
    for (int k = 28; k <= 32; k++) begin
      setIn(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
      applyStimulus("hiloStall", mkExp(1, 0, 0, 1, (k == 32) ? 1 : 0, 2 + k - 28));
    end
    setIn(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0); applyStimulus("hiloGo", mkExp(0, 0, 0, 0, 0, 7));

    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); applyStimulus("md2Start", mkExp(0, 0, 1, 0, 0, 7));
    for (int k = 1; k <= 32; k++) begin
      setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0);
      applyStimulus("md2Stall", mkExp(1, 0, 0, 1, (k == 32) ? 1 : 0, 7 + k - 1));
    end
    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); applyStimulus("md2Issue", mkExp(0, 0, 1, 0, 0, 39));

    for (int k = 1; k <= 22; k++) begin
      idleIn(); applyStimulus("md2Busy", mkExp(0, 0, 0, 1, 0, 39));
    end
    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1); applyStimulus("brMdBusy", mkExp(0, 1, 0, 1, 0, 39));
    for (int k = 24; k <= 33; k++) begin
      idleIn();
      applyStimulus("brMdCount", mkExp(0, 0, 0, (k <= 32) ? 1 : 0, (k == 32) ? 1 : 0, 39));
    end
    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1); applyStimulus("brNoStart", mkExp(0, 1, 0, 0, 0, 39));
    idleIn(); applyStimulus("brNoStartAfter", mkExp(0, 0, 0, 0, 0, 39));
    setIn(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 1); applyStimulus("brLd", mkExp(0, 1, 0, 0, 0, 39));
    idleIn(); applyStimulus("brLdAfter", mkExp(0, 0, 0, 0, 0, 39));

    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); applyStimulus("md3Start", mkExp(0, 0, 1, 0, 0, 39));
    setIn(5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0); applyStimulus("bothHaz", mkExp(1, 0, 0, 1, 0, 39));
    for (int k = 2; k <= 22; k++) begin
      idleIn(); applyStimulus("md3Busy", mkExp(0, 0, 0, 1, 0, 40));
    end
    idleIn(); rstN = 1'b0; applyStimulus("preReset", mkExp(0, 0, 0, 1, 0, 40));
    idleIn(); rstN = 1'b1; applyStimulus("rstMidMd", mkExp(0, 0, 0, 0, 0, 0));
    for (int k = 25; k <= 33; k++) begin
      idleIn(); applyStimulus("noDoneAfterRst", mkExp(0, 0, 0, 0, 0, 0));
    end

    @(negedge clk); sel = 1'b1;
    idleIn(); applyStimulus("bIdle", mkExp(0, 0, 0, 0, 0, 0));
    setIn(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0); applyStimulus("bLd0", mkExp(1, 0, 0, 0, 0, 0));
    idleIn(); applyStimulus("bLd1", mkExp(1, 0, 0, 0, 0, 1));
    idleIn(); applyStimulus("bLd2", mkExp(1, 0, 0, 0, 0, 2));
    idleIn(); applyStimulus("bLdEnd", mkExp(0, 0, 0, 0, 0, 3));
    setIn(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0); applyStimulus("bLd3", mkExp(1, 0, 0, 0, 0, 3));
    setIn(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1); applyStimulus("bBrInLd", mkExp(0, 1, 0, 0, 0, 4));
    idleIn(); applyStimulus("bBrAfter", mkExp(0, 0, 0, 0, 0, 4));

    setIn(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0); applyStimulus("bMdStart", mkExp(0, 0, 1, 0, 0, 4));
    for (int k = 1; k <= 4; k++) begin
      setIn(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0);
      applyStimulus("bHiloStall", mkExp(1, 0, 0, 1, (k == 4) ? 1 : 0, 4 + k - 1));
    end
    setIn(5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0); applyStimulus("bMdGo", mkExp(0, 0, 0, 0, 0, 8));

    for (int i = 0; i < 20; i++) begin
      setIn(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0);
      applyStimulus("bSat", mkExp(1, 0, 0, 0, 0, (8 + i > 15) ? 15 : 8 + i));
    end
    idleIn(); applyStimulus("bSatTail", mkExp(1, 0, 0, 0, 0, 15));
    idleIn(); applyStimulus("bSatHold", mkExp(0, 0, 0, 0, 0, 15));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
